// File: rtl/bf16_norm.sv
// BF16 post-add normalisation: leading-zero count, shift, exponent adjust, pack.
// Define BF16_NORM_RNE_EN for round-to-nearest-even; otherwise the fraction is truncated.

module lzc #(
    parameter int W  = 16,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  data,
    output logic [CW-1:0] count
);
    generate
        if (W == 2) begin : g_leaf
            always_comb begin
                case (data)
                    2'b00:   count = CW'(2);
                    2'b01:   count = CW'(1);
                    default: count = CW'(0);
                endcase
            end
        end else begin : g_tree
            localparam int HW  = W / 2;
            localparam int HCW = $clog2(HW + 1);
            logic [HCW-1:0] count_hi;
            logic [HCW-1:0] count_lo;

            lzc #(.W(HW)) u_hi (.data(data[W-1:HW]), .count(count_hi));
            lzc #(.W(HW)) u_lo (.data(data[HW-1:0]), .count(count_lo));

            // Only when the upper half is all zeros does the lower half contribute.
            always_comb begin
                if (count_hi == HCW'(HW))
                    count = CW'(HW) + CW'(count_lo);
                else
                    count = CW'(count_hi);
            end
        end
    endgenerate
endmodule

module bf16_norm #(
    parameter int W    = 16,
    parameter int LZ_W = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic          sign_i,
    input  logic [8:0]    exp_i,
    input  logic [W-1:0]  mant_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [15:0]   res_o,
    output logic          zero_o,
    output logic          of_o,
    output logic          uf_o
);
    logic            s1_valid;
    logic            s1_sign;
    logic [8:0]      s1_exp;
    logic [W-1:0]    s1_mant;
    logic [LZ_W-1:0] s1_lz;
    logic            s1_mzero;
    logic [LZ_W-1:0] lz;

    logic            s2_adv;
    logic            s1_adv;

    logic [LZ_W-1:0] shift;
    logic [W-1:0]    norm;
    logic [9:0]      nexp;
    logic            dropped;
    logic            take_zero;
    logic            take_uf;
    logic [6:0]      frac;
    logic [6:0]      frac_r;
    logic [9:0]      exp_r;
    logic            unused_bits;

    logic [15:0]     res_n;
    logic            zero_n;
    logic            of_n;
    logic            uf_n;

    lzc #(.W(W), .CW(LZ_W)) u_lzc (.data(mant_i), .count(lz));

    assign s2_adv  = ~valid_o | ready_i;
    assign s1_adv  = ~s1_valid | s2_adv;
    assign ready_o = s1_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_mant  <= '0;
            s1_lz    <= '0;
            s1_mzero <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= valid_i;
            if (valid_i) begin
                s1_sign  <= sign_i;
                s1_exp   <= exp_i;
                s1_mant  <= mant_i;
                s1_lz    <= lz;
                s1_mzero <= (mant_i == '0);
            end
        end
    end

    // A nonzero, non-carry magnitude has lz >= 1, so shift never wraps where it is used.
    assign shift = s1_lz - LZ_W'(1);

    always_comb begin
        norm      = '0;
        nexp      = '0;
        dropped   = 1'b0;
        take_zero = 1'b0;
        take_uf   = 1'b0;
        if (s1_mzero) begin
            take_zero = 1'b1;
        end else if (s1_exp == '0) begin
            take_uf = 1'b1;
        end else if (s1_mant[W-1]) begin
            norm    = s1_mant >> 1;
            dropped = s1_mant[0];
            nexp    = {1'b0, s1_exp} + 10'd1;
        end else if ({1'b0, s1_exp} > 10'(shift)) begin
            norm = s1_mant << shift;
            nexp = {1'b0, s1_exp} - 10'(shift);
        end else begin
            take_uf = 1'b1;
        end
    end

    assign frac = norm[W-3:W-9];

`ifdef BF16_NORM_RNE_EN
    logic       guard;
    logic       sticky;
    logic       round_up;
    logic [7:0] frac_sum;

    assign guard       = norm[W-10];
    assign sticky      = dropped | (|norm[W-11:0]);
    assign round_up    = guard & (sticky | frac[0]);
    assign frac_sum    = {1'b0, frac} + 8'(round_up);
    assign frac_r      = frac_sum[6:0];
    assign exp_r       = nexp + 10'(frac_sum[7]);
    assign unused_bits = ^norm[W-1:W-2];
`else
    assign frac_r      = frac;
    assign exp_r       = nexp;
    assign unused_bits = ^{norm[W-1:W-2], norm[W-10:0], dropped};
`endif

    always_comb begin
        res_n  = {s1_sign, exp_r[7:0], frac_r};
        zero_n = 1'b0;
        of_n   = 1'b0;
        uf_n   = 1'b0;
        if (take_zero || take_uf) begin
            res_n  = {s1_sign, 15'h0};
            zero_n = 1'b1;
            uf_n   = take_uf;
        end else if (exp_r >= 10'd255) begin
            res_n = {s1_sign, 8'hFF, 7'h0};
            of_n  = 1'b1;
        end
    end

    // Output register only loads when downstream can take it, so a stall freezes the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o <= 1'b0;
            res_o   <= '0;
            zero_o  <= 1'b0;
            of_o    <= 1'b0;
            uf_o    <= 1'b0;
        end else if (s2_adv) begin
            valid_o <= s1_valid;
            if (s1_valid) begin
                res_o  <= res_n;
                zero_o <= zero_n;
                of_o   <= of_n;
                uf_o   <= uf_n;
            end
        end
    end
endmodule

// File: tb/tb_bf16_norm.sv
// Self-checking bench for bf16_norm: vector table through a scoreboard, plus stall and reset sequences.
// Expectations follow BF16_NORM_RNE_EN the same way the design does.

module tb_bf16_norm;
    localparam int W = 16;

    typedef struct {
        logic        sign;
        logic [8:0]  exp;
        logic [15:0] mant;
        logic [15:0] res;
        logic        zero;
        logic        of;
        logic        uf;
    } vec_t;

    typedef struct {
        vec_t v;
        int   cyc;
    } sb_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic          sign_i = 1'b0;
    logic [8:0]    exp_i = '0;
    logic [W-1:0]  mant_i = '0;
    logic          valid_o;
    logic          ready_i = 1'b1;
    logic [15:0]   res_o;
    logic          zero_o;
    logic          of_o;
    logic          uf_o;

    vec_t  vecs[$];
    sb_t   sb[$];
    int    vec_count = 0;
    int    miscompares = 0;
    int    cyc = 0;
    logic  lat_check = 1'b1;
    logic  stall_pending = 1'b0;
    logic [18:0] held = '0;

    always #5 clk = ~clk;

    bf16_norm #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .ready_o(ready_o),
        .sign_i(sign_i), .exp_i(exp_i), .mant_i(mant_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .res_o(res_o), .zero_o(zero_o), .of_o(of_o), .uf_o(uf_o)
    );

    function automatic vec_t mk(logic s, logic [8:0] e, logic [15:0] m,
                                logic [15:0] r, logic z, logic o, logic u);
        vec_t v;
        v.sign = s; v.exp = e; v.mant = m; v.res = r; v.zero = z; v.of = o; v.uf = u;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        vec_count++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic fail(string name, string msg);
        vec_count++;
        miscompares++;
        $display("[TB] FAIL %s: %s", name, msg);
    endtask

    task automatic check_output();
        sb_t e;
        if (stall_pending)
            check("stall_hold", {13'h0, valid_o, res_o, zero_o, of_o, uf_o}, {13'h0, 1'b1, held});
        if (valid_o && ready_i) begin
            if (sb.size() == 0) begin
                fail("spurious_output", $sformatf("got res %h with nothing outstanding", res_o));
            end else begin
                e = sb.pop_front();
                check($sformatf("result s=%0d e=%0d m=%h", e.v.sign, e.v.exp, e.v.mant),
                      {13'h0, res_o, zero_o, of_o, uf_o},
                      {13'h0, e.v.res, e.v.zero, e.v.of, e.v.uf});
                if (lat_check)
                    check("latency", cyc - e.cyc, 2);
            end
        end
        stall_pending = valid_o && !ready_i;
        held = {res_o, zero_o, of_o, uf_o};
    endtask

    // One cycle: drive at the falling edge, let logic settle, then observe and score.
    task automatic apply_stimulus(input vec_t v, input logic vld, input logic rdy, output logic acc);
        sb_t e;
        @(negedge clk);
        valid_i = vld;
        sign_i  = v.sign;
        exp_i   = v.exp;
        mant_i  = v.mant;
        ready_i = rdy;
        #1;
        cyc++;
        check_output();
        acc = vld && ready_o;
        if (acc) begin
            e.v = v;
            e.cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input int bound);
        logic acc;
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < bound && sb.size() != 0; i++)
            apply_stimulus(idle, 1'b0, 1'b1, acc);
        if (sb.size() != 0)
            fail("drain_timeout", $sformatf("%0d results never appeared", sb.size()));
        sb.delete();
        for (int i = 0; i < 3; i++)
            apply_stimulus(idle, 1'b0, 1'b1, acc);
    endtask

    initial begin
        logic acc;
        int   j;
        int   stream_idx[4];

        vecs.push_back(mk(0, 127, 16'h4000, 16'h3F80, 0, 0, 0));
        vecs.push_back(mk(0, 127, 16'h8000, 16'h4000, 0, 0, 0));
        vecs.push_back(mk(0, 127, 16'h0100, 16'h3C80, 0, 0, 0));
        vecs.push_back(mk(0, 10,  16'h0001, 16'h0000, 1, 0, 1));
        vecs.push_back(mk(1, 254, 16'h8000, 16'hFF80, 0, 1, 0));
        vecs.push_back(mk(1, 50,  16'h0000, 16'h8000, 1, 0, 0));
        vecs.push_back(mk(0, 0,   16'h0000, 16'h0000, 1, 0, 0));
        vecs.push_back(mk(0, 0,   16'h4000, 16'h0000, 1, 0, 1));
        vecs.push_back(mk(0, 15,  16'h0001, 16'h0080, 0, 0, 0));
        vecs.push_back(mk(0, 14,  16'h0001, 16'h0000, 1, 0, 1));
        vecs.push_back(mk(0, 255, 16'h4000, 16'h7F80, 0, 1, 0));
        vecs.push_back(mk(0, 254, 16'h4000, 16'h7F00, 0, 0, 0));
        vecs.push_back(mk(0, 127, 16'h5A00, 16'h3FB4, 0, 0, 0));
        vecs.push_back(mk(1, 100, 16'hC001, 16'hB2C0, 0, 0, 0));
        vecs.push_back(mk(0, 127, 16'h4040, 16'h3F80, 0, 0, 0));
        vecs.push_back(mk(1, 510, 16'h0001, 16'hFF80, 0, 1, 0));
`ifdef BF16_NORM_RNE_EN
        vecs.push_back(mk(0, 127, 16'h40C0, 16'h3F82, 0, 0, 0));
        vecs.push_back(mk(0, 127, 16'h7FFF, 16'h4000, 0, 0, 0));
        vecs.push_back(mk(0, 254, 16'h7FFF, 16'h7F80, 0, 1, 0));
`else
        vecs.push_back(mk(0, 127, 16'h40C0, 16'h3F81, 0, 0, 0));
        vecs.push_back(mk(0, 127, 16'h7FFF, 16'h3FFF, 0, 0, 0));
        vecs.push_back(mk(0, 254, 16'h7FFF, 16'h7F7F, 0, 0, 0));
`endif

        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {12'h0, valid_o, res_o, zero_o, of_o, uf_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back stream of the whole table at full throughput.
        lat_check = 1'b1;
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i], 1'b1, 1'b1, acc);
            if (!acc)
                fail("accept_table", $sformatf("vector %0d refused with ready_i high", i));
        end
        drain(20);

        // Four inputs back to back with the consumer stalled for three cycles.
        lat_check = 1'b0;
        stream_idx = '{1, 2, 4, 12};
        j = 0;
        for (int k = 0; k < 30 && (j < 4 || sb.size() != 0); k++) begin
            apply_stimulus(vecs[stream_idx[j < 4 ? j : 3]], j < 4, k >= 3, acc);
            if (k == 2)
                check("ready_o_full_stall", {31'h0, ready_o}, 32'h0);
            if (acc)
                j++;
        end
        if (j != 4)
            fail("stream_accept", $sformatf("only %0d of 4 inputs accepted", j));
        drain(20);

        // Reset with results in flight, then one fresh transaction.
        lat_check = 1'b1;
        apply_stimulus(vecs[0], 1'b1, 1'b1, acc);
        apply_stimulus(vecs[1], 1'b1, 1'b1, acc);
        @(negedge clk);
        valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("reset_mid_valid_o", {31'h0, valid_o}, 32'h0);
        check("reset_mid_outputs", {16'h0, res_o, zero_o, of_o, uf_o}, 32'h0);
        sb.delete();
        stall_pending = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(vecs[13], 1'b1, 1'b1, acc);
        if (!acc)
            fail("accept_after_reset", "first post-reset input refused");
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end
endmodule
